// File: rtl/conv_window_feeder.sv
// -----------------------------------------------------------------------------
// conv_window_feeder
//   Producer side of the convolution engine's img/val window interface.
//   Accepts a row-major pixel stream (valid/ready) and emits one packed
//   IMG_NB-pixel window per output position, never straddling a row boundary.
//   The output side has no backpressure and never stalls.
//
//   Optional feature (compile-time macro WINDOW_PAD_EN):
//     Rows are zero-padded by PAD=(IMG_NB-1)/2 pixels on both sides, giving
//     ROW_LEN windows per row. The trailing padding is produced in the FLUSH
//     state, during which pix_ready is low. Without the macro PAD=0 and the
//     FLUSH state is unreachable.
//
// Ports:
//   clk        system clock, all state on posedge
//   rst        asynchronous active-low reset
//   pix_data   input pixel (signed, passed through bit-exact)
//   pix_valid  pix_data is valid
//   pix_ready  pixel accepted when pix_valid && pix_ready
//   img        window; lane k = img[k*IMG_WIDTH +: IMG_WIDTH], lane 0 oldest
//   val        single-cycle pulse: img holds a new window
// -----------------------------------------------------------------------------
module conv_window_feeder #(
  parameter int IMG_WIDTH = 16,
  parameter int IMG_NB    = 3,
  parameter int ROW_LEN   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IMG_WIDTH-1:0] pix_data,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic [IMG_WIDTH*IMG_NB-1:0] img,
  output logic                        val
);

  localparam int COL_W_RAW = $clog2(ROW_LEN);
  localparam int COL_W     = (COL_W_RAW < 1) ? 1 : COL_W_RAW;
  localparam int WIN_W     = IMG_WIDTH * IMG_NB;
`ifdef WINDOW_PAD_EN
  localparam int PAD       = (IMG_NB - 1) / 2;
  localparam bit PAD_EN    = 1'b1;
`else
  localparam int PAD       = 0;
  localparam bit PAD_EN    = 1'b0;
`endif
  localparam int FLUSH_W   = (PAD > 1) ? $clog2(PAD) : 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(ROW_LEN - 1);
  localparam logic [COL_W-1:0]   VAL_FROM   = COL_W'(IMG_NB - 1 - PAD);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'((PAD > 0) ? PAD - 1 : 0);

  typedef enum logic {STREAM, FLUSH} state_t;

  state_t             state_p0, state_d;
  logic               rdy_en_p0;
  logic [COL_W-1:0]   col_p0, col_d;
  logic [FLUSH_W-1:0] fcnt_p0, fcnt_d;
  logic [WIN_W-1:0]   win_p1, win_d;
  logic               vld_p1, vld_d;
  logic               accept;

  // Shift the window one lane towards lane 0 and insert p as the newest lane.
  function automatic logic [WIN_W-1:0] shift_in(input logic [WIN_W-1:0] w,
                                                input logic [IMG_WIDTH-1:0] p);
    logic [WIN_W-1:0] r;
    r = w >> IMG_WIDTH;
    r[WIN_W-IMG_WIDTH +: IMG_WIDTH] = p;
    return r;
  endfunction

  // rdy_en_p0 holds pix_ready low until the first edge after reset release.
  assign pix_ready = rdy_en_p0 && (state_p0 == STREAM);
  assign accept    = pix_valid && pix_ready;
  assign img       = win_p1;
  assign val       = vld_p1;

  // ---- stage p0: accept decision, column/flush control -> next window ----
  always_comb begin
    state_d = state_p0;
    col_d   = col_p0;
    fcnt_d  = fcnt_p0;
    win_d   = win_p1;
    vld_d   = 1'b0;
    case (state_p0)
      STREAM: begin
        if (accept) begin
          // With padding, a new row starts from an all-zero left margin.
          if (PAD_EN && (col_p0 == '0)) win_d = shift_in('0, pix_data);
          else                          win_d = shift_in(win_p1, pix_data);
          vld_d = (col_p0 >= VAL_FROM);
          if (col_p0 == COL_LAST) begin
            col_d = '0;
            if (PAD > 0) begin
              state_d = FLUSH;
              fcnt_d  = '0;
            end
          end else begin
            col_d = col_p0 + 1'b1;
          end
        end
      end
      FLUSH: begin
        // Right margin: shift in zeros, each one completing a window.
        win_d = shift_in(win_p1, '0);
        vld_d = 1'b1;
        if (fcnt_p0 == FLUSH_LAST) begin
          state_d = STREAM;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_p0 + 1'b1;
        end
      end
      default: state_d = STREAM;
    endcase
  end

  // ---- stage p1: registered window and its valid pulse ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0  <= STREAM;
      rdy_en_p0 <= 1'b0;
      col_p0    <= '0;
      fcnt_p0   <= '0;
      win_p1    <= '0;
      vld_p1    <= 1'b0;
    end else begin
      state_p0  <= state_d;
      rdy_en_p0 <= 1'b1;
      col_p0    <= col_d;
      fcnt_p0   <= fcnt_d;
      win_p1    <= win_d;
      vld_p1    <= vld_d;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;

  localparam int W  = 16;
  localparam int NB = 3;
  localparam int RL = 8;
`ifdef WINDOW_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic signed [W-1:0]   pix_data = '0;
  logic                  pix_valid = 1'b0;
  logic                  pix_ready;
  logic [W*NB-1:0]       img;
  logic                  val;

  int n_cmp = 0;
  int n_bad = 0;
  int nwin  = 0;

  logic [W*NB-1:0] exp_q[$];
  int              mrow[RL];
  int              mcol = 0;

  typedef struct {
    logic vld;
    int   pix;
    logic ev;
    logic ci;
    int   e0, e1, e2;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_WIDTH(W), .IMG_NB(NB), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .img(img), .val(val)
  );

  function automatic logic [W*NB-1:0] pack3(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  function automatic int rowpix(input int c);
    if (c < 0 || c >= RL) return 0;
    return mrow[c];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void add(input logic vld, input int pix, input logic ev,
                              input logic ci, input int e0, input int e1, input int e2);
    vec_t v;
    v.vld = vld; v.pix = pix; v.ev = ev; v.ci = ci; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    tbl.push_back(v);
  endfunction

  // Scoreboard producer: an independent row-buffer model of the expected windows.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      mcol = 0;
    end else if (pix_valid && pix_ready) begin
      int c;
      c = mcol;
      mrow[c] = int'(pix_data);
      if (c >= NB - 1 - PAD)
        exp_q.push_back(pack3(rowpix(c - 2), rowpix(c - 1), rowpix(c)));
      if (c == RL - 1) begin
        if (PAD > 0) exp_q.push_back(pack3(rowpix(c - 1), rowpix(c), 0));
        mcol = 0;
      end else begin
        mcol = c + 1;
      end
    end
  end

  // Scoreboard consumer: every val pulse must match the oldest expected window.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      exp_q.delete();
    end else if (val) begin
      nwin++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_window: got %0h, required no window (t=%0t)", img, $time);
      end else begin
        check("sb_window", img, exp_q.pop_front());
      end
    end
  end

  task automatic push_pix(input int v);
    int guard;
    guard = 0;
    pix_valid = 1'b1;
    pix_data  = W'(v);
    while (!pix_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_wait", pix_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_tbl(input int from, input int to);
    for (int i = from; i < to; i++) begin
      pix_valid = tbl[i].vld;
      pix_data  = W'(tbl[i].pix);
      @(posedge clk); #1;
      check("tbl_val", val, tbl[i].ev);
      if (tbl[i].ci) check("tbl_img", img, pack3(tbl[i].e0, tbl[i].e1, tbl[i].e2));
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // continuous row 1..8
    for (int p = 1; p <= 8; p++) add(1, p, p >= 3, p >= 3, p - 2, p - 1, p);
    // back-to-back rows 1..8, 11..18
    for (int r = 0; r < 2; r++) begin
      int b;
      b = (r == 0) ? 1 : 11;
      for (int p = b; p < b + 8; p++)
        add(1, p, p >= b + 2, p >= b + 2, p - 2, p - 1, p);
    end
    // gapped row: accept, idle, accept, idle ...
    for (int p = 1; p <= 8; p++) begin
      add(1, p, p >= 3, p >= 3, p - 2, p - 1, p);
      add(0, 0, 0, p >= 3, p - 2, p - 1, p);
    end

    // Reset state
    rst = 1'b0;
    #12;
    check("rst_ready", pix_ready, 0);
    check("rst_val", val, 0);
    check("rst_img", img, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("ready_at_release", pix_ready, 0);
    @(posedge clk); #1;
    check("ready_after_edge", pix_ready, 1);

`ifndef WINDOW_PAD_EN
    nwin = 0;
    run_tbl(0, 8);
    idle(3);
    check("cont_windows", nwin, 6);

    nwin = 0;
    run_tbl(8, 24);
    idle(3);
    check("b2b_windows", nwin, 12);

    nwin = 0;
    run_tbl(24, 40);
    idle(3);
    check("gap_windows", nwin, 6);

    // Reset mid-row after four accepts
    for (int p = 1; p <= 4; p++) push_pix(p);
    rst = 1'b0;
    #1;
    check("midrow_rst_val", val, 0);
    check("midrow_rst_img", img, 0);
    check("midrow_rst_ready", pix_ready, 0);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrow_ready_release", pix_ready, 0);
    @(posedge clk); #1;
    check("midrow_ready_edge", pix_ready, 1);
    nwin = 0;
    push_pix(1); push_pix(2); push_pix(3);
    check("midrow_first_val", val, 1);
    check("midrow_first_img", img, pack3(1, 2, 3));
    for (int p = 4; p <= 8; p++) push_pix(p);
    idle(3);
    check("midrow_windows", nwin, 6);
`else
    // Padded row with the next row's first pixel held during FLUSH
    nwin = 0;
    for (int p = 1; p <= 8; p++) push_pix(p);
    check("pad_flush_ready", pix_ready, 0);
    check("pad_last_img", img, pack3(6, 7, 8));
    pix_valid = 1'b1;
    pix_data  = W'(9);
    @(posedge clk); #1;
    check("pad_flush_img", img, pack3(7, 8, 0));
    check("pad_flush_val", val, 1);
    check("pad_ready_back", pix_ready, 1);
    for (int p = 9; p <= 16; p++) push_pix(p);
    idle(4);
    check("pad_windows", nwin, 16);

    // Reset during the FLUSH cycle
    nwin = 0;
    for (int p = 1; p <= 8; p++) push_pix(p);
    pix_valid = 1'b0;
    #5;
    rst = 1'b0;
    #1;
    check("flush_rst_ready", pix_ready, 0);
    check("flush_rst_val", val, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("flush_ready_release", pix_ready, 0);
    @(posedge clk); #1;
    check("flush_ready_edge", pix_ready, 1);
    push_pix(1);
    check("flush_col0_val", val, 0);
    push_pix(2);
    check("flush_next_val", val, 1);
    check("flush_next_img", img, pack3(0, 1, 2));
    idle(3);
    check("flush_windows", nwin, 8);
`endif

    check("leftover_expected", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the convolution engine's `img`/`val` window interface.
- Takes a serial, row-major pixel stream with a valid/ready handshake.
- Keeps an IMG_NB-deep sliding window per row and emits one packed window plus a single-cycle `val` per output position.
- Windows never straddle a row boundary.
- Sits directly upstream of the MAC chain, which has no backpressure, so the output side never stalls.

Parameters:
- IMG_WIDTH, 16, bits per pixel (signed, passed through unmodified).
- IMG_NB, 3, window length in pixels; must be odd and >= 1.
- ROW_LEN, 8, pixels per image row; must be >= IMG_NB.
- COL_W, $clog2(ROW_LEN), column counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- pix_data  in  IMG_WIDTH  input pixel.
- pix_valid  in  1  pix_data is valid.
- pix_ready  out  1  block accepts pix_data this cycle; a pixel is accepted when pix_valid && pix_ready.
- img  out  IMG_WIDTH*IMG_NB  window; lane k = img[k*IMG_WIDTH +: IMG_WIDTH]; lane 0 is oldest, lane IMG_NB-1 is newest.
- val  out  1  img holds a new window this cycle (single-cycle pulse per window).

Behaviour:
- Reset (rst=0, asynchronous):
  - img=0, val=0, pix_ready=0, column counter col=0, flush counter=0, state=STREAM.
  - pix_ready rises on the first clk edge after release.
  - Reset mid-row or mid-flush discards the partial window; the next accepted pixel is column 0.
- Window register:
  - On each accept, lane k <= lane k+1 for k < IMG_NB-1, and lane IMG_NB-1 <= pix_data.
  - img is the window register itself, so a window appears 1 cycle after its newest pixel is accepted.
  - img holds its value when nothing is accepted.
- val:
  - Registered. val=1 in the cycle after an accept where col >= IMG_NB-1-PAD; otherwise 0.
  - PAD=0 by default; see Optional Feature.
- Column counter:
  - col increments on each accept and wraps from ROW_LEN-1 to 0.
  - With PAD=0 this gives exactly ROW_LEN-IMG_NB+1 windows per row.
  - With ROW_LEN==IMG_NB there is exactly one window per row.
  - With IMG_NB=1 every accepted pixel produces a window.
- States:
  - STREAM: pix_ready=1.
  - FLUSH: pix_ready=0; used only with the Optional Feature. Without it, pix_ready stays 1 after reset.
- Lane arithmetic: none; pixels pass through bit-exact.

Optional Feature:
- Macro: WINDOW_PAD_EN.
- When defined, PAD = (IMG_NB-1)/2 and rows are zero-padded on both sides, giving exactly ROW_LEN windows per row.
  - Accepting a pixel with col==0 loads lanes 0..IMG_NB-2 with 0 and lane IMG_NB-1 with pix_data.
  - val threshold is col >= PAD.
  - After accepting col==ROW_LEN-1 with PAD>0, enter FLUSH for exactly PAD cycles. Each FLUSH cycle shifts in a zero pixel and asserts val the following cycle. pix_ready=0 throughout, so held input is not consumed.
  - After the final FLUSH cycle, return to STREAM with col=0.
  - With PAD=0, FLUSH is never entered.
- When undefined, PAD=0, there is no FLUSH state, and pix_ready=1 permanently after reset.

Test Plan:
- Reset: assert rst=0 mid-row after 4 accepts, then release. Required: val=0, img=0, pix_ready=0 while low; pix_ready=1 one edge after release; next row of pixels 1..8 yields its first window {1,2,3}.
- No pad, IMG_NB=3, ROW_LEN=8, pix_valid=1 continuously, pixels 1..8. Required: 6 val pulses on consecutive cycles; windows (lane0,lane1,lane2) = {1,2,3}, {2,3,4}, ... {6,7,8}; first val 1 cycle after accepting pixel 3.
- Back-to-back rows 1..8 then 11..18. Required: 12 windows total; second row's first window is {11,12,13}; no window contains both 8 and 11; val is low for 2 cycles between rows.
- Gapped input: pix_valid alternates 1/0 over pixels 1..8. Required: val pulses only the cycle after accepts of pixels 3..8; img stable on idle cycles; 6 windows with the same values as the continuous case.
- WINDOW_PAD_EN, IMG_NB=3, ROW_LEN=8, pixels 1..8, pix_valid held high. Required: 8 windows {0,1,2}, {1,2,3}, ... {6,7,8}, {7,8,0}; pix_ready=0 for exactly 1 cycle after accepting pixel 8; pixel 9 held on input is accepted as column 0 of the next row.
- WINDOW_PAD_EN: assert reset during the FLUSH cycle. Required: no {7,8,0} window; pix_ready=0 during reset and 1 after release; col=0, so the next pixels 1,2 produce window {0,1,2}.
